sram_1r1w_adapter: RTL and testbench

- Front-end for the behavioural 1R1W SRAM macro (mem_0_ext geometry: 512 x 64 bit, byte mask).
- Converts a single valid/ready request stream into the macro's separate write and read port controls.
- Absorbs the macro's 1-cycle read latency and captures read data into a response FIFO, so downstream backpressure never loses data.
- Optionally zero-fills the whole array after reset, so software never sees random init contents.

---
 rtl/sram_1r1w_adapter_pkg.sv | 22 ++
 rtl/sram_1r1w_adapter_if.sv | 39 +++
 rtl/sram_1r1w_adapter_rsp_fifo.sv | 84 ++++++++
 rtl/sram_1r1w_adapter.sv | 136 +++++++++++++
 tb/tb_sram_1r1w_adapter.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_1r1w_adapter_pkg.sv
// -----------------------------------------------------------------------------
// sram_adapter_pkg
// Shared types and constants for the 1R1W SRAM front-end.
//   state_e  : adapter FSM states (INIT = zero-fill sweep, RUN = normal traffic)
//   BE_W     : byte-enable width for the default 64-bit macro word
//   be_width : byte-enable width for an arbitrary data width
// -----------------------------------------------------------------------------
package sram_adapter_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int DEFAULT_DATA_W = 64;
   localparam int BE_W           = DEFAULT_DATA_W / 8;

   function automatic int be_width(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/sram_1r1w_adapter_if.sv
// -----------------------------------------------------------------------------
// sram_1r1w_adapter_if
// Request/response bus of the SRAM adapter.
//
// Handshake: a beat transfers on a rising clock edge where valid && ready.
// The source holds valid and its payload stable until that edge; ready may
// depend combinationally on the payload, valid may not depend on ready.
//
//   req_valid / req_ready : request handshake (master -> adapter)
//   req_we                : 1 = write, 0 = read
//   req_addr              : word address
//   req_wdata / req_be    : write data and byte enables
//   rsp_valid / rsp_ready : read response handshake (adapter -> master)
//   rsp_rdata             : read data
// -----------------------------------------------------------------------------
interface sram_1r1w_adapter_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 64
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic [DATA_W/8-1:0]   req_be;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_W-1:0]     rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/sram_1r1w_adapter_rsp_fifo.sv
// -----------------------------------------------------------------------------
// sram_rsp_fifo
// Synchronous register-based FIFO holding read responses.
//   clk_i, rst_ni : clock, synchronous active-low reset (clears pointers/count)
//   push_i/data_i : write one entry (caller guarantees the FIFO is not full)
//   pop_i         : remove the head entry when valid_o is high
//   valid_o       : FIFO not empty
//   data_o        : head entry, read straight from storage registers
//   count_o       : number of stored entries
// -----------------------------------------------------------------------------
module sram_rsp_fifo #(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = 64,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic [CNT_W-1:0] count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_pop;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_pop  = pop_i && (count_q != '0);
   assign valid_o = (count_q != '0);
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push_i, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible once counted.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

`ifndef SYNTHESIS
   no_push_when_full_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      push_i |-> (count_q != CNT_W'(DEPTH)));
`endif

endmodule

// File: rtl/sram_1r1w_adapter.sv
// -----------------------------------------------------------------------------
// sram_1r1w_adapter
// Front-end for a 1R1W SRAM macro with 1-cycle read latency and byte mask.
// Splits one request stream into the macro's write and read ports, captures
// read data into a response FIFO and optionally zero-fills the array after
// reset.
//   clk_i, rst_ni    : clock (also the macro clock), sync active-low reset
//   bus (slave)      : request/response handshake bus
//   init_done_o      : high once the zero-fill sweep has finished
//   sram_w_*_o       : macro write port (en, addr, data, mask)
//   sram_r_en_o/addr : macro read port controls
//   sram_r_data_i    : macro read data for the address registered last cycle
//   dbg_state_o      : current FSM state
// -----------------------------------------------------------------------------
module sram_1r1w_adapter
   import sram_adapter_pkg::*;
#(
   parameter  int ADDR_W    = 9,
   parameter  int DATA_W    = 64,
   parameter  int RSP_DEPTH = 2,
   parameter  int INIT_ZERO = 1,
   localparam int BEW       = be_width(DATA_W)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   sram_1r1w_adapter_if.slave  bus,
   output logic                init_done_o,
   output logic                sram_w_en_o,
   output logic [ADDR_W-1:0]   sram_w_addr_o,
   output logic [DATA_W-1:0]   sram_w_data_o,
   output logic [BEW-1:0]      sram_w_mask_o,
   output logic                sram_r_en_o,
   output logic [ADDR_W-1:0]   sram_r_addr_o,
   input  logic [DATA_W-1:0]   sram_r_data_i,
   output state_e              dbg_state_o
);

   localparam int     CNT_W       = $clog2(RSP_DEPTH + 1);
   localparam state_e RESET_STATE = (INIT_ZERO != 0) ? INIT : RUN;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              rd_pend_q, rd_pend_d;
   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W:0]    inflight;
   logic              credit_ok;
   logic              req_ready;
   logic              fire;
   logic              rsp_pop;

   // A read is only accepted when a FIFO slot is guaranteed for it, counting
   // the read already in flight in the macro.
   assign inflight  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_pend_q};
   assign credit_ok = (inflight < (CNT_W + 1)'(RSP_DEPTH));
   assign rsp_pop   = bus.rsp_valid && bus.rsp_ready;

   assign bus.req_ready = req_ready;
   assign dbg_state_o   = state_q;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      rd_pend_d     = 1'b0;
      req_ready     = 1'b0;
      fire          = 1'b0;
      init_done_o   = 1'b0;
      sram_w_en_o   = 1'b0;
      sram_w_addr_o = bus.req_addr;
      sram_w_data_o = bus.req_wdata;
      sram_w_mask_o = bus.req_be;
      sram_r_en_o   = 1'b0;
      sram_r_addr_o = bus.req_addr;

      case (state_q)
         INIT: begin
            // Suppressed while reset is held so the sweep begins cleanly.
            sram_w_en_o   = rst_ni;
            sram_w_addr_o = cnt_q;
            sram_w_data_o = '0;
            sram_w_mask_o = '1;
            if (cnt_q == '1) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end
         RUN: begin
            init_done_o = 1'b1;
            req_ready   = bus.req_we ? 1'b1 : credit_ok;
            fire        = bus.req_valid && req_ready && rst_ni;
            sram_w_en_o = fire && bus.req_we;
            sram_r_en_o = fire && !bus.req_we;
            rd_pend_d   = sram_r_en_o;
         end
         default: begin
            state_d = RESET_STATE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= RESET_STATE;
         cnt_q     <= '0;
         rd_pend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_pend_q <= rd_pend_d;
      end
   end

   // The macro output is only valid for one cycle, so the pending read is
   // captured unconditionally; the credit check makes room beforehand.
   sram_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .WIDTH (DATA_W)
   ) u_rsp_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (rd_pend_q),
      .data_i  (sram_r_data_i),
      .pop_i   (rsp_pop),
      .valid_o (bus.rsp_valid),
      .data_o  (bus.rsp_rdata),
      .count_o (fifo_count)
   );

`ifndef SYNTHESIS
   req_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (bus.req_valid && !bus.req_ready) |=>
         (bus.req_valid && $stable(bus.req_we) && $stable(bus.req_addr) &&
          $stable(bus.req_wdata) && $stable(bus.req_be)));
`endif

endmodule

// File: tb/tb_sram_1r1w_adapter.sv
// -----------------------------------------------------------------------------
// tb_sram_1r1w_adapter
// Directed bench for sram_1r1w_adapter with a behavioural 1R1W macro model
// (random power-up contents) and a reference memory feeding a response
// scoreboard.
// -----------------------------------------------------------------------------
module tb_sram_1r1w_adapter;
   import sram_adapter_pkg::*;

   localparam int ADDR_W    = 9;
   localparam int DATA_W    = 64;
   localparam int DEPTH     = 1 << ADDR_W;
   localparam int RSP_DEPTH = 2;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sram_1r1w_adapter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   logic              init_done;
   logic              w_en;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_data;
   logic [BE_W-1:0]   w_mask;
   logic              r_en;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   state_e            dbg_state;

   sram_1r1w_adapter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .RSP_DEPTH (RSP_DEPTH),
      .INIT_ZERO (1)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .bus           (bus.slave),
      .init_done_o   (init_done),
      .sram_w_en_o   (w_en),
      .sram_w_addr_o (w_addr),
      .sram_w_data_o (w_data),
      .sram_w_mask_o (w_mask),
      .sram_r_en_o   (r_en),
      .sram_r_addr_o (r_addr),
      .sram_r_data_i (r_data),
      .dbg_state_o   (dbg_state)
   );

   // ---------------- behavioural macro ----------------
   logic [DATA_W-1:0] sram_mem [DEPTH];
   logic [ADDR_W-1:0] sram_raddr_q = '0;
   logic              seeded       = 1'b0;

   always @(posedge clk) begin
      if (!seeded) begin
         for (int i = 0; i < DEPTH; i++) sram_mem[i] <= {$urandom, $urandom};
         seeded <= 1'b1;
      end else begin
         if (w_en) begin
            for (int b = 0; b < BE_W; b++)
               if (w_mask[b]) sram_mem[w_addr][b*8 +: 8] <= w_data[b*8 +: 8];
         end
         if (r_en) sram_raddr_q <= r_addr;
      end
   end
   assign r_data = sram_mem[sram_raddr_q];

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [DATA_W-1:0] ref_mem [DEPTH];
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] last_rsp = '1;
   int                n_rsp    = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference memory: zero after every reset (zero-fill), updated by every
   // accepted write; each accepted read queues the value it must return.
   always @(negedge clk) begin
      logic [DATA_W-1:0] exp_v;
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
         exp_q.delete();
      end else begin
         if (bus.req_valid && bus.req_ready) begin
            if (bus.req_we) begin
               for (int b = 0; b < BE_W; b++)
                  if (bus.req_be[b]) ref_mem[bus.req_addr][b*8 +: 8] = bus.req_wdata[b*8 +: 8];
            end else begin
               exp_q.push_back(ref_mem[bus.req_addr]);
            end
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               exp_v = exp_q.pop_front();
               check("rsp_rdata", bus.rsp_rdata, exp_v);
               last_rsp = bus.rsp_rdata;
               n_rsp++;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data, input logic [BE_W-1:0] be);
      int   n;
      logic acc;
      n   = 0;
      acc = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = data;
      bus.req_be    = be;
      while (!acc && n < 50) begin
         @(negedge clk);
         if (bus.req_ready) begin
            acc = 1'b1;
            check("sram_w_en", 64'(w_en), 64'(we));
            check("sram_r_en", 64'(r_en), 64'(!we));
            check("sram_addr", 64'(we ? w_addr : r_addr), 64'(addr));
         end
         n++;
         @(posedge clk); #1;
      end
      check("req_accept_timeout", 64'(acc), 64'd1);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.rsp_valid) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_timeout", 64'(n < 100), 64'd1);
   endtask

   // Called at posedge+1 right after reset release; counts INIT cycles.
   task automatic wait_init(output int n);
      n = 0;
      @(negedge clk);
      while (!init_done && n < 2000) begin
         if (n == 0) begin
            check("init_first_w_en", 64'(w_en), 64'd1);
            check("init_first_addr", 64'(w_addr), 64'd0);
            check("init_mask", 64'(w_mask), 64'hFF);
            check("init_data", w_data, 64'd0);
         end
         if (n == DEPTH - 1) check("init_last_addr", 64'(w_addr), 64'h1FF);
         check("ready_in_init", 64'(bus.req_ready), 64'd0);
         n++;
         @(negedge clk);
      end
      @(posedge clk); #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      int n_acc;
      int base;

      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_be    = '0;
      bus.rsp_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 64'(bus.req_ready), 64'd0);
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("rst_init_done", 64'(init_done), 64'd0);
      check("rst_w_en", 64'(w_en), 64'd0);
      check("rst_r_en", 64'(r_en), 64'd0);
      check("rst_state", 64'(dbg_state), 64'(INIT));
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Zero-fill lasts exactly 2**ADDR_W cycles
      wait_init(n);
      check("init_cycles", 64'(n), 64'd512);
      check("run_state", 64'(dbg_state), 64'(RUN));

      // Top word was zero-filled over random contents
      base = n_rsp;
      do_req(1'b0, 9'h1FF, '0, '0);
      wait_idle();
      check("zero_fill_1ff", last_rsp, 64'd0);
      check("zero_fill_cnt", 64'(n_rsp - base), 64'd1);

      // Write then read next cycle; response two cycles after acceptance
      do_req(1'b1, 9'h010, 64'hDEADBEEF_CAFEF00D, 8'hFF);
      do_req(1'b0, 9'h010, '0, '0);
      @(negedge clk);
      check("lat_n1_valid", 64'(bus.rsp_valid), 64'd0);
      @(negedge clk);
      check("lat_n2_valid", 64'(bus.rsp_valid), 64'd1);
      check("lat_n2_rdata", bus.rsp_rdata, 64'hDEADBEEF_CAFEF00D);
      @(posedge clk); #1;
      wait_idle();

      // Partial write over zeroed memory
      do_req(1'b1, 9'h022, 64'h11223344_55667788, 8'h0F);
      do_req(1'b0, 9'h022, '0, '0);
      wait_idle();
      check("partial_write", last_rsp, 64'h00000000_55667788);

      // Credit limit: back-to-back reads of 0..7 with rsp_ready low
      for (int i = 0; i < 8; i++)
         do_req(1'b1, ADDR_W'(i), {32'hC0DE_0000 + 32'(i), 32'(i * 7 + 1)}, 8'hFF);
      base = n_rsp;
      bus.rsp_ready = 1'b0;
      n_acc = 0;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.req_ready) n_acc++;
         @(posedge clk); #1;
         bus.req_addr = ADDR_W'(n_acc);
      end
      check("credit_accepts", 64'(n_acc), 64'd2);
      @(negedge clk);
      check("credit_ready_low", 64'(bus.req_ready), 64'd0);
      check("credit_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;
      n = 0;
      while (n_acc < 8 && n < 100) begin
         @(negedge clk);
         if (bus.req_ready) n_acc++;
         n++;
         @(posedge clk); #1;
         if (n_acc < 8) bus.req_addr = ADDR_W'(n_acc);
      end
      bus.req_valid = 1'b0;
      check("credit_all_accepted", 64'(n_acc), 64'd8);
      wait_idle();
      check("credit_rsp_count", 64'(n_rsp - base), 64'd8);
      check("credit_last_rsp", last_rsp, {32'hC0DE_0007, 32'd50});

      // Read of A followed by write of A returns old data
      do_req(1'b1, 9'h030, 64'hAAAA, 8'hFF);
      bus.rsp_ready = 1'b0;
      do_req(1'b0, 9'h030, '0, '0);
      do_req(1'b1, 9'h030, 64'hBBBB, 8'hFF);
      repeat (5) @(posedge clk);
      #1;
      bus.rsp_ready = 1'b1;
      wait_idle();
      check("war_old_data", last_rsp, 64'hAAAA);
      do_req(1'b0, 9'h030, '0, '0);
      wait_idle();
      check("war_new_data", last_rsp, 64'hBBBB);

      // Reset with two responses queued
      bus.rsp_ready = 1'b0;
      do_req(1'b0, 9'h010, '0, '0);
      do_req(1'b0, 9'h022, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("queued_valid", 64'(bus.rsp_valid), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("midrst_state", 64'(dbg_state), 64'(INIT));
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      base = n_rsp;
      wait_init(n);
      check("reinit_cycles", 64'(n), 64'd512);
      do_req(1'b0, 9'h010, '0, '0);
      wait_idle();
      check("reinit_zero", last_rsp, 64'd0);
      check("reinit_rsp_count", 64'(n_rsp - base), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time bound
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
